// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions used by the slice-serial theta, rho and pi stages.
//   NSLICE   : slices per state (lane width), power of two
//   ZW       : slice index width, log2(NSLICE)
//   NLANE    : bits per slice, lane i = x + 5*y
//   slice_t  : one slice, bit i = lane i at the current z
//   col_t    : five column parities C[x] of one slice
//   state_e  : LOAD / EMIT phase of the slice-serial stages
package keccak_pkg;

   localparam int NSLICE = 64;
   localparam int ZW     = 6;
   localparam int NLANE  = 25;
   localparam int NCOL   = 5;

   typedef logic [0:NLANE-1] slice_t;
   typedef logic [0:NCOL-1]  col_t;

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Lane number of sheet position (x, y).
   function automatic int lane_idx(input int x, input int y);
      return x + 5 * y;
   endfunction

endpackage

// File: rtl/keccak_theta_slice_if.sv
// Slice stream bundle of the theta stage: input slice stream, output slice
// stream with index/last marker, and the end-of-state pulse.
//   slave  : view of the theta block
//   master : view of the producer/consumer driving the block
interface keccak_theta_slice_if;
   import keccak_pkg::*;

   logic            in_valid;
   logic            in_ready;
   slice_t          in_slice;
   logic            out_valid;
   logic            out_ready;
   slice_t          out_slice;
   logic [ZW-1:0]   out_z;
   logic            out_last;
   logic            co;

   modport slave (
      input  in_valid, in_slice, out_ready,
      output in_ready, out_valid, out_slice, out_z, out_last, co
   );

   modport master (
      output in_valid, in_slice, out_ready,
      input  in_ready, out_valid, out_slice, out_z, out_last, co
   );

endinterface

// File: rtl/keccak_col_parity.sv
// Combinational column parity of one slice: col_o[x] = XOR over y of slice_i[x+5y].
//   slice_i : slice_t, incoming slice
//   col_o   : col_t, five column parities
module keccak_col_parity
   import keccak_pkg::*;
(
   input  slice_t slice_i,
   output col_t   col_o
);

   // XOR the five rows of each column.
   always_comb begin
      col_t par;
      par = '0;
      for (int x = 0; x < NCOL; x++) begin
         for (int y = 0; y < 5; y++) begin
            par[x] = par[x] ^ slice_i[lane_idx(x, y)];
         end
      end
      col_o = par;
   end

endmodule

// File: rtl/keccak_theta_slice.sv
// Keccak-f[1600] theta step, slice-serial. LOAD stores 64 slices and their
// column parities; EMIT streams slice ^ D out through a registered output stage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   io  : slave view of keccak_theta_slice_if (in/out slice streams, co pulse)
module keccak_theta_slice
   import keccak_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   keccak_theta_slice_if.slave   io
);

   state_e          state_q, state_d;
   logic [ZW-1:0]   z_q, z_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   slice_t          out_slice_q, out_slice_d;
   logic [ZW-1:0]   out_z_q, out_z_d;
   logic            out_last_q, out_last_d;
   logic            co_q, co_d;

   // Not reset: every entry is rewritten by the next LOAD before EMIT reads it.
   slice_t          sbuf_q [NSLICE];
   col_t            cbuf_q [NSLICE];

   col_t            col_par;
   slice_t          theta_slice;
   logic            in_fire;
   logic            out_fire;

   keccak_col_parity u_col_parity (
      .slice_i (io.in_slice),
      .col_o   (col_par)
   );

   assign in_fire  = io.in_valid && in_ready_q;
   assign out_fire = out_valid_q && io.out_ready;

   // Theta of slice z_q; z_q - 1 wraps 0 -> 63 through the ZW-bit subtraction.
   always_comb begin
      col_t c_cur;
      col_t c_prev;
      col_t d_col;
      c_cur       = cbuf_q[z_q];
      c_prev      = cbuf_q[z_q - ZW'(1)];
      d_col       = '0;
      theta_slice = '0;
      for (int x = 0; x < NCOL; x++) begin
         d_col[x] = c_cur[(x + 4) % 5] ^ c_prev[(x + 1) % 5];
      end
      for (int x = 0; x < NCOL; x++) begin
         for (int y = 0; y < 5; y++) begin
            theta_slice[lane_idx(x, y)] = sbuf_q[z_q][lane_idx(x, y)] ^ d_col[x];
         end
      end
   end

   // Phase control, slice counter and output-stage refill.
   always_comb begin
      state_d     = state_q;
      z_d         = z_q;
      out_valid_d = out_valid_q;
      out_slice_d = out_slice_q;
      out_z_d     = out_z_q;
      out_last_d  = out_last_q;
      co_d        = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               if (z_q == ZW'(NSLICE - 1)) begin
                  state_d = EMIT;
                  z_d     = '0;
               end else begin
                  z_d = z_q + ZW'(1);
               end
            end else begin
               z_d = z_q;
            end
         end
         EMIT: begin
            if (out_fire && out_last_q) begin
               state_d     = LOAD;
               z_d         = '0;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               co_d        = 1'b1;
            end else if (!out_valid_q || out_fire) begin
               // Output stage empty or draining: load slice z_q, no bubble between slices.
               out_valid_d = 1'b1;
               out_slice_d = theta_slice;
               out_z_d     = z_q;
               out_last_d  = (z_q == ZW'(NSLICE - 1));
               z_d         = z_q + ZW'(1);
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: begin
            state_d = LOAD;
            z_d     = '0;
         end
      endcase
      // Registered ready follows the next phase, so it drops the cycle after slice 63 is taken.
      in_ready_d = (state_d == LOAD);
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         z_q         <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_slice_q <= '0;
         out_z_q     <= '0;
         out_last_q  <= 1'b0;
         co_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_slice_q <= out_slice_d;
         out_z_q     <= out_z_d;
         out_last_q  <= out_last_d;
         co_q        <= co_d;
      end
   end

   // Slice and column-parity buffers, written on each accepted input slice.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         sbuf_q[z_q] <= io.in_slice;
         cbuf_q[z_q] <= col_par;
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.out_slice = out_slice_q;
   assign io.out_z     = out_z_q;
   assign io.out_last  = out_last_q;
   assign io.co        = co_q;

endmodule

// File: tb/tb_keccak_theta_slice.sv
// Directed bench for keccak_theta_slice: hand-derived theta results for
// special states, a lane-level theta model for random states under
// backpressure, and a mid-load reset.
module tb_keccak_theta_slice;
   import keccak_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   logic [63:0] st_lanes  [25];
   slice_t      load_slice[64];
   slice_t      exp_slice [64];
   slice_t      m_d0;
   slice_t      m_d1;

   keccak_theta_slice_if bus ();

   keccak_theta_slice dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic build_slices();
      for (int z = 0; z < 64; z++) begin
         for (int i = 0; i < 25; i++) begin
            load_slice[z][i] = st_lanes[i][z];
         end
      end
   endtask

   // Lane-level theta: C[x] = XOR of column lanes, D[x] = C[x-1] ^ rot(C[x+1], 1).
   task automatic theta_model();
      logic [63:0] c [5];
      logic [63:0] d [5];
      logic [63:0] o [25];
      for (int x = 0; x < 5; x++) begin
         c[x] = st_lanes[x] ^ st_lanes[x+5] ^ st_lanes[x+10] ^ st_lanes[x+15] ^ st_lanes[x+20];
      end
      for (int x = 0; x < 5; x++) begin
         d[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][62:0], c[(x + 1) % 5][63]};
      end
      for (int i = 0; i < 25; i++) begin
         o[i] = st_lanes[i] ^ d[i % 5];
      end
      for (int z = 0; z < 64; z++) begin
         for (int i = 0; i < 25; i++) begin
            exp_slice[z][i] = o[i][z];
         end
      end
   endtask

   task automatic clear_state();
      for (int i = 0; i < 25; i++) st_lanes[i] = 64'd0;
      for (int z = 0; z < 64; z++) exp_slice[z] = '0;
   endtask

   // Load one state, drain it, and check every slice plus the co pulse.
   task automatic run_state(input string tag, input int gap_pct, input int stall_pct);
      int     z;
      int     got;
      int     budget;
      int     co_cnt;
      bit     held;
      slice_t held_slice;
      logic [ZW-1:0] held_z;
      z = 0; budget = 0; co_cnt = 0; held = 1'b0;
      held_slice = '0; held_z = '0;
      build_slices();
      bus.out_ready = 1'b0;
      while (z < 64 && budget < 5000) begin
         @(negedge clk);
         budget++;
         if (bus.co) co_cnt++;
         bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
         bus.in_slice = load_slice[z];
         if (bus.in_valid && bus.in_ready) z++;
      end
      check($sformatf("%s load_count", tag), 64'(z), 64'd64);
      if (gap_pct == 0) check($sformatf("%s load_cycles", tag), 64'(budget), 64'd64);
      got = 0; budget = 0;
      while (got < 64 && budget < 5000) begin
         @(negedge clk);
         budget++;
         bus.in_valid = 1'b0;
         if (bus.co) co_cnt++;
         if (held) begin
            check($sformatf("%s hold_valid z%0d", tag, got), 64'(bus.out_valid), 64'd1);
            check($sformatf("%s hold_slice z%0d", tag, got), 64'(bus.out_slice), 64'(held_slice));
            check($sformatf("%s hold_z z%0d", tag, got), 64'(bus.out_z), 64'(held_z));
         end
         bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
         held = 1'b0;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               if (got == 0) check($sformatf("%s in_ready_emit", tag), 64'(bus.in_ready), 64'd0);
               check($sformatf("%s z z%0d", tag, got), 64'(bus.out_z), 64'(got));
               check($sformatf("%s last z%0d", tag, got), 64'(bus.out_last), 64'(got == 63));
               check($sformatf("%s slice z%0d", tag, got), 64'(bus.out_slice), 64'(exp_slice[got]));
               got++;
            end else begin
               held       = 1'b1;
               held_slice = bus.out_slice;
               held_z     = bus.out_z;
            end
         end
      end
      check($sformatf("%s emit_count", tag), 64'(got), 64'd64);
      if (stall_pct == 0) check($sformatf("%s emit_cycles", tag), 64'(budget), 64'd65);
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (bus.co) co_cnt++;
      check($sformatf("%s co_pulse", tag), 64'(bus.co), 64'd1);
      check($sformatf("%s out_valid_end", tag), 64'(bus.out_valid), 64'd0);
      check($sformatf("%s in_ready_end", tag), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      if (bus.co) co_cnt++;
      check($sformatf("%s co_count", tag), 64'(co_cnt), 64'd1);
   endtask

   task automatic random_state();
      for (int i = 0; i < 25; i++) st_lanes[i] = {$urandom(), $urandom()};
      theta_model();
   endtask

   initial begin
      int n;
      int co_cnt;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_slice  = '0;
      bus.out_ready = 1'b0;
      m_d0 = '0;
      m_d1 = '0;
      m_d0[0] = 1'b1;
      for (int y = 0; y < 5; y++) begin
         m_d0[1 + 5 * y] = 1'b1;
         m_d1[4 + 5 * y] = 1'b1;
      end

      repeat (2) @(negedge clk);
      check("rst in_ready",  64'(bus.in_ready),  64'd0);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst out_slice", 64'(bus.out_slice), 64'd0);
      check("rst out_z",     64'(bus.out_z),     64'd0);
      check("rst out_last",  64'(bus.out_last),  64'd0);
      check("rst co",        64'(bus.co),        64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst in_ready", 64'(bus.in_ready), 64'd1);

      // All-zero state.
      clear_state();
      run_state("zero", 0, 0);

      // Single bit lane 0, z = 0.
      clear_state();
      st_lanes[0][0] = 1'b1;
      exp_slice[0] = m_d0;
      exp_slice[1] = m_d1;
      run_state("bit_z0", 0, 0);

      // Single bit lane 0, z = 63: D wraps into slice 0.
      clear_state();
      st_lanes[0][63] = 1'b1;
      exp_slice[63] = m_d0;
      exp_slice[0]  = m_d1;
      run_state("bit_z63", 0, 0);

      // All ones: every column parity is 1, so D = 0.
      for (int i = 0; i < 25; i++) st_lanes[i] = '1;
      for (int z = 0; z < 64; z++) exp_slice[z] = '1;
      run_state("ones", 0, 0);

      // Random states under input gaps and output backpressure.
      random_state();
      run_state("rnd_a", 30, 50);
      random_state();
      run_state("rnd_b", 50, 50);

      // Reset after 30 accepted slices, then a full new state.
      for (int i = 0; i < 25; i++) st_lanes[i] = {$urandom(), $urandom()};
      build_slices();
      n = 0; co_cnt = 0;
      while (n < 30) begin
         @(negedge clk);
         if (bus.co) co_cnt++;
         bus.in_valid = 1'b1;
         bus.in_slice = load_slice[n];
         if (bus.in_ready) n++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst in_ready",  64'(bus.in_ready),  64'd0);
      check("midrst out_valid", 64'(bus.out_valid), 64'd0);
      if (bus.co) co_cnt++;
      @(negedge clk);
      check("midrst in_ready_back", 64'(bus.in_ready), 64'd1);
      check("midrst no_co", 64'(co_cnt), 64'd0);
      random_state();
      run_state("after_rst", 20, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
